// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer sharing one memory port between instruction fetch and data access.
// Define MEM_ARB_TIMEOUT_EN to abort transactions that wait TIMEOUT_CYCLES without mem_ready.
module mem_port_arbiter #(
    parameter int XLEN           = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic [XLEN-1:0]   if_rdata,
    output logic              if_valid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [3:0]        dm_be,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [XLEN-1:0]   dm_wdata,
    output logic [XLEN-1:0]   dm_rdata,
    output logic              dm_valid,
    output logic              bus_err,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ready,
    input  logic [XLEN-1:0]   mem_rdata
);

    typedef enum logic [1:0] {IDLE, DATA, FETCH} state_t;

    state_t state;
    logic   kill_pending;
    logic   dm_eligible;
    logic   if_eligible;
    logic   fetch_dropped;

    // A requester whose valid is high this cycle is consuming its result, not asking again.
    assign dm_eligible   = dm_req & ~dm_valid;
    assign if_eligible   = if_req & ~if_valid & ~if_kill;
    assign fetch_dropped = kill_pending | if_kill;
    assign stall_if      = if_req & ~if_valid;
    assign stall_mem     = dm_req & ~dm_valid;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;

    // Fires on the last permitted wait cycle so mem_req is high for exactly TIMEOUT_CYCLES cycles.
    assign timeout_hit = ~mem_ready & (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            kill_pending <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_be       <= 4'h0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            if_rdata     <= '0;
            dm_rdata     <= '0;
            if_valid     <= 1'b0;
            dm_valid     <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_cnt     <= '0;
            bus_err      <= 1'b0;
`endif
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            bus_err  <= 1'b0;
            if (state != IDLE && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
`endif
            case (state)
                IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    // MEM stage holds the older instruction, so data wins.
                    if (dm_eligible) begin
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_be    <= dm_be;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        state     <= DATA;
                    end else if (if_eligible) begin
                        mem_req      <= 1'b1;
                        mem_we       <= 1'b0;
                        mem_be       <= 4'hF;
                        mem_addr     <= if_addr;
                        kill_pending <= 1'b0;
                        state        <= FETCH;
                    end
                end
                DATA: begin
                    if (mem_ready) begin
                        dm_rdata <= mem_rdata;
                        dm_valid <= 1'b1;
                        mem_req  <= 1'b0;
                        state    <= IDLE;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (timeout_hit) begin
                        dm_rdata <= '0;
                        dm_valid <= 1'b1;
                        bus_err  <= 1'b1;
                        mem_req  <= 1'b0;
                        state    <= IDLE;
                    end
`endif
                end
                FETCH: begin
                    // A killed fetch still finishes on the bus; only its result is dropped.
                    if (mem_ready) begin
                        mem_req      <= 1'b0;
                        kill_pending <= 1'b0;
                        state        <= IDLE;
                        if (!fetch_dropped) begin
                            if_rdata <= mem_rdata;
                            if_valid <= 1'b1;
                        end
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (timeout_hit) begin
                        mem_req      <= 1'b0;
                        kill_pending <= 1'b0;
                        state        <= IDLE;
                        if (!fetch_dropped) begin
                            if_rdata <= '0;
                            if_valid <= 1'b1;
                            bus_err  <= 1'b1;
                        end
                    end
`endif
                    else if (if_kill) begin
                        kill_pending <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// run against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_kill, dm_req, dm_we, mem_ready;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [3:0]  dm_be;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_valid, dm_valid, bus_err, stall_if, stall_mem, mem_req, mem_we;
    logic [3:0]  mem_be;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .bus_err(bus_err), .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        if_req = 1'b0; dm_req = 1'b0; if_kill = 1'b0; mem_ready = 1'b1;
        repeat (4) tick();
        mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0101; dm_addr = 32'h40; dm_wdata = 32'h1234_5678;
        if_req = 1'b1; if_addr = 32'h80; if_kill = 1'b0;
        mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({mem_req, mem_we, mem_be, if_valid, dm_valid, bus_err} !== 9'd0 ||
                mem_addr !== 32'd0 || mem_wdata !== 32'd0 || if_rdata !== 32'd0 || dm_rdata !== 32'd0) begin
                failures++;
                $display("FAIL reset_regs cycle=%0d mem_req=%b we=%b be=%h addr=%h wdata=%h if_rdata=%h dm_rdata=%h valids=%b%b err=%b required all 0",
                         i, mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_rdata, dm_rdata, if_valid, dm_valid, bus_err);
            end
        end
        rst = 1'b0; mem_ready = 1'b0;
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b0101 || mem_addr !== 32'h40 || mem_wdata !== 32'h1234_5678) begin
            failures++;
            $display("FAIL reset_first_cmd got req=%b we=%b be=%h addr=%h wdata=%h required 1 1 5 00000040 12345678",
                     mem_req, mem_we, mem_be, mem_addr, mem_wdata);
        end
        mem_ready = 1'b1; mem_rdata = 32'd0;
        tick();
        checks++;
        if (dm_valid !== 1'b1 || if_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_done got dm_valid=%b if_valid=%b required 1 0", dm_valid, if_valid);
        end
        settle();
    endtask

    task automatic test_single_fetch();
        int stall_cycles = 0;
        if_req = 1'b1; if_addr = 32'h100; mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
        #1;
        if (stall_if === 1'b1) stall_cycles++;
        tick();
        if (stall_if === 1'b1) stall_cycles++;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0 || mem_be !== 4'hF || if_valid !== 1'b0) begin
            failures++;
            $display("FAIL fetch_cmd got req=%b addr=%h we=%b be=%h if_valid=%b required 1 00000100 0 f 0",
                     mem_req, mem_addr, mem_we, mem_be, if_valid);
        end
        tick();
        if (stall_if === 1'b1) stall_cycles++;
        checks++;
        if (if_valid !== 1'b1 || if_rdata !== 32'h0050_0093 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL fetch_done got if_valid=%b if_rdata=%h mem_req=%b required 1 00500093 0", if_valid, if_rdata, mem_req);
        end
        checks++;
        if (stall_cycles != 2) begin
            failures++;
            $display("FAIL fetch_stall_len got=%0d required=2", stall_cycles);
        end
        // req still held during the valid cycle must not be re-issued
        tick();
        checks++;
        if (mem_req !== 1'b0 || if_valid !== 1'b0) begin
            failures++;
            $display("FAIL fetch_no_reissue got mem_req=%b if_valid=%b required 0 0", mem_req, if_valid);
        end
        settle();
    endtask

    task automatic test_simultaneous();
        dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF;
        if_req = 1'b1; if_addr = 32'h104; mem_ready = 1'b1; mem_rdata = 32'h1111_1111;
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b0011 || mem_addr !== 32'h200 || mem_wdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL simul_store_cmd got req=%b we=%b be=%h addr=%h wdata=%h required 1 1 3 00000200 deadbeef",
                     mem_req, mem_we, mem_be, mem_addr, mem_wdata);
        end
        tick();
        checks++;
        if (dm_valid !== 1'b1 || if_valid !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL simul_store_done got dm_valid=%b if_valid=%b mem_req=%b required 1 0 0", dm_valid, if_valid, mem_req);
        end
        dm_req = 1'b0; mem_rdata = 32'h2222_2222;
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h104 || mem_we !== 1'b0 || mem_be !== 4'hF || if_valid !== 1'b0) begin
            failures++;
            $display("FAIL simul_fetch_cmd got req=%b addr=%h we=%b be=%h if_valid=%b required 1 00000104 0 f 0",
                     mem_req, mem_addr, mem_we, mem_be, if_valid);
        end
        tick();
        checks++;
        if (if_valid !== 1'b1 || if_rdata !== 32'h2222_2222 || dm_valid !== 1'b0) begin
            failures++;
            $display("FAIL simul_fetch_done got if_valid=%b if_rdata=%h dm_valid=%b required 1 22222222 0", if_valid, if_rdata, dm_valid);
        end
        settle();
    endtask

    task automatic test_kill();
        if_req = 1'b1; if_addr = 32'h2F0; mem_ready = 1'b1; mem_rdata = 32'h0000_0013;
        tick(); tick();
        checks++;
        if (if_valid !== 1'b1 || if_rdata !== 32'h0000_0013) begin
            failures++;
            $display("FAIL kill_setup got if_valid=%b if_rdata=%h required 1 00000013", if_valid, if_rdata);
        end
        if_addr = 32'h2F4; mem_ready = 1'b0;
        tick(); tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h2F4) begin
            failures++;
            $display("FAIL kill_issue got req=%b addr=%h required 1 000002f4", mem_req, mem_addr);
        end
        if_kill = 1'b1; if_addr = 32'h300;
        tick();
        if_kill = 1'b0;
        for (int w = 0; w < 2; w++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h2F4 || if_valid !== 1'b0) begin
                failures++;
                $display("FAIL kill_hold w=%0d got req=%b addr=%h if_valid=%b required 1 000002f4 0", w, mem_req, mem_addr, if_valid);
            end
            tick();
        end
        mem_ready = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        tick();
        checks++;
        if (if_valid !== 1'b0 || if_rdata !== 32'h0000_0013 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL kill_drop got if_valid=%b if_rdata=%h mem_req=%b required 0 00000013 0", if_valid, if_rdata, mem_req);
        end
        mem_rdata = 32'h0030_0313;
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h300 || if_valid !== 1'b0) begin
            failures++;
            $display("FAIL kill_refetch_cmd got req=%b addr=%h if_valid=%b required 1 00000300 0", mem_req, mem_addr, if_valid);
        end
        tick();
        checks++;
        if (if_valid !== 1'b1 || if_rdata !== 32'h0030_0313) begin
            failures++;
            $display("FAIL kill_refetch_done got if_valid=%b if_rdata=%h required 1 00300313", if_valid, if_rdata);
        end
        settle();
    endtask

    task automatic test_wait_states();
        dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'b1100; dm_addr = 32'h400; dm_wdata = 32'hCAFE_F00D;
        mem_ready = 1'b0; mem_rdata = 32'h5555_5555;
        tick();
        for (int c = 1; c <= 6; c++) begin
            if (c == 6) begin
                mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
            end
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h400 || mem_we !== 1'b0 || mem_be !== 4'b1100 ||
                mem_wdata !== 32'hCAFE_F00D || dm_valid !== 1'b0) begin
                failures++;
                $display("FAIL wait_hold c=%0d got req=%b addr=%h we=%b be=%h wdata=%h dm_valid=%b required 1 00000400 0 c cafef00d 0",
                         c, mem_req, mem_addr, mem_we, mem_be, mem_wdata, dm_valid);
            end
            tick();
        end
        checks++;
        if (dm_valid !== 1'b1 || dm_rdata !== 32'h0BAD_F00D || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL wait_done got dm_valid=%b dm_rdata=%h mem_req=%b required 1 0badf00d 0", dm_valid, dm_rdata, mem_req);
        end
        settle();
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h500; dm_wdata = 32'h0;
        mem_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        tick();
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (mem_req !== 1'b1 || dm_valid !== 1'b0) begin
                failures++;
                $display("FAIL timeout_wait c=%0d got req=%b dm_valid=%b required 1 0", c, mem_req, dm_valid);
            end
            tick();
        end
        checks++;
        if (mem_req !== 1'b0 || dm_valid !== 1'b1 || bus_err !== 1'b1 || dm_rdata !== 32'd0) begin
            failures++;
            $display("FAIL timeout_abort got req=%b dm_valid=%b bus_err=%b dm_rdata=%h required 0 1 1 00000000",
                     mem_req, dm_valid, bus_err, dm_rdata);
        end
        dm_req = 1'b0;
        tick();
        checks++;
        if (dm_valid !== 1'b0 || bus_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_pulse got dm_valid=%b bus_err=%b required 0 0", dm_valid, bus_err);
        end
        settle();
    endtask
`endif

    // Transaction-level model: the port is either free or serving one command; when free,
    // the next edge starts whichever requester is eligible (data first); each command
    // yields exactly one result on its own port the cycle after the memory answers.
    task automatic test_random();
        logic        dm_act, if_act, busy, busy_fetch, fetch_killed;
        logic        issue_pending, issue_fetch, dut_idle, dm_elig, if_elig;
        logic        exp_dmv, exp_ifv, exp_dm_load, dmv_now, ifv_now;
        logic [31:0] exp_dmd, exp_ifd, c_addr, c_wdata, rd;
        logic        c_we;
        logic [3:0]  c_be;
        int          waits;
        dm_act = 0; if_act = 0; busy = 0; busy_fetch = 0; fetch_killed = 0;
        issue_pending = 0; issue_fetch = 0; exp_dmv = 0; exp_ifv = 0; exp_dm_load = 0;
        exp_dmd = 0; exp_ifd = 0; c_addr = 0; c_wdata = 0; c_we = 0; c_be = 0; waits = 0;
        if_req = 0; dm_req = 0; if_kill = 0; mem_ready = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            tick();
            dmv_now = exp_dmv;
            ifv_now = exp_ifv;
            checks++;
            if (dm_valid !== exp_dmv || (exp_dmv && exp_dm_load && dm_rdata !== exp_dmd)) begin
                failures++;
                $display("FAIL rnd_dm_result cyc=%0d got valid=%b rdata=%h required valid=%b rdata=%h",
                         cyc, dm_valid, dm_rdata, exp_dmv, exp_dmd);
            end
            checks++;
            if (if_valid !== exp_ifv || (exp_ifv && if_rdata !== exp_ifd)) begin
                failures++;
                $display("FAIL rnd_if_result cyc=%0d got valid=%b rdata=%h required valid=%b rdata=%h",
                         cyc, if_valid, if_rdata, exp_ifv, exp_ifd);
            end
            checks++;
            if (bus_err !== 1'b0) begin
                failures++;
                $display("FAIL rnd_bus_err cyc=%0d got=%b required=0", cyc, bus_err);
            end
            exp_dmv = 0;
            exp_ifv = 0;
            if (!busy) begin
                checks++;
                if (mem_req !== issue_pending) begin
                    failures++;
                    $display("FAIL rnd_issue cyc=%0d got mem_req=%b required=%b", cyc, mem_req, issue_pending);
                end
                if (issue_pending) begin
                    busy = 1; busy_fetch = issue_fetch; fetch_killed = 0;
                    waits = int'($urandom_range(0, 3));
                end
            end
            if (busy) begin
                checks++;
                if (mem_req !== 1'b1 || mem_addr !== c_addr || mem_we !== c_we || mem_be !== c_be ||
                    (!busy_fetch && mem_wdata !== c_wdata)) begin
                    failures++;
                    $display("FAIL rnd_cmd cyc=%0d fetch=%b got req=%b addr=%h we=%b be=%h wdata=%h required 1 %h %b %h %h",
                             cyc, busy_fetch, mem_req, mem_addr, mem_we, mem_be, mem_wdata, c_addr, c_we, c_be, c_wdata);
                end
            end
            dut_idle = !busy;
            if (dmv_now) dm_act = 0;
            if (ifv_now) if_act = 0;
            if (!dm_act && $urandom_range(0, 2) == 0) begin
                dm_act = 1; dm_we = 1'($urandom_range(0, 1)); dm_be = 4'($urandom_range(0, 15));
                dm_addr = $urandom & 32'hFFFF_FFFC; dm_wdata = $urandom;
            end
            dm_req = dm_act;
            if (!if_act && $urandom_range(0, 1) == 0) begin
                if_act = 1; if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if_kill = 1'b0;
            if (if_act && !ifv_now && $urandom_range(0, 9) == 0) begin
                if_kill = 1'b1;
                if (busy && busy_fetch) fetch_killed = 1;
                if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if_req = if_act;
            #1;
            checks++;
            if (stall_if !== (if_req & ~ifv_now) || stall_mem !== (dm_req & ~dmv_now)) begin
                failures++;
                $display("FAIL rnd_stall cyc=%0d got if=%b mem=%b required if=%b mem=%b",
                         cyc, stall_if, stall_mem, if_req & ~ifv_now, dm_req & ~dmv_now);
            end
            if (busy) begin
                if (waits == 0) begin
                    rd = $urandom; mem_ready = 1'b1; mem_rdata = rd; busy = 0;
                    if (busy_fetch) begin
                        if (!fetch_killed) begin
                            exp_ifv = 1; exp_ifd = rd;
                        end
                    end else begin
                        exp_dmv = 1; exp_dmd = rd; exp_dm_load = !c_we;
                    end
                end else begin
                    waits--; mem_ready = 1'b0; mem_rdata = $urandom;
                end
            end else begin
                mem_ready = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
            end
            dm_elig = dm_req && !dmv_now;
            if_elig = if_req && !ifv_now && !if_kill;
            issue_pending = dut_idle && (dm_elig || if_elig);
            if (issue_pending) begin
                issue_fetch = !dm_elig;
                if (dm_elig) begin
                    c_addr = dm_addr; c_we = dm_we; c_be = dm_be; c_wdata = dm_wdata;
                end else begin
                    c_addr = if_addr; c_we = 1'b0; c_be = 4'hF;
                end
            end
        end
        settle();
    endtask

    initial begin
        rst = 1'b1; if_req = 0; if_addr = 0; if_kill = 0; dm_req = 0; dm_we = 0;
        dm_be = 0; dm_addr = 0; dm_wdata = 0; mem_ready = 0; mem_rdata = 0;
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_kill();
        test_wait_states();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for the single unified memory port of the pipelined RISC-V core, shared between the instruction-fetch (IF) and data-memory (MEM) stages. It serialises the two requesters onto one request/ready memory interface and holds captured read data until the requester consumes it. It also generates `stall_if`/`stall_mem` toward the hazard unit so the pipeline freezes while a transaction is outstanding. A fetch that is killed by a taken branch (`PCSrcE`) finishes on the bus, but its result is discarded.

## Interface
- `XLEN`, 32, data width.
- `ADDR_W`, 32, address width.
- `TIMEOUT_CYCLES`, 64, wait-cycle limit before a transaction is aborted (used only with the macro).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `if_req`  in  1  fetch request; held until `if_valid` is seen.
- `if_addr`  in  ADDR_W  fetch address.
- `if_kill`  in  1  discard in-flight/pending fetch (driven by `PCSrcE`).
- `if_rdata`  out  XLEN  fetched instruction.
- `if_valid`  out  1  one-cycle fetch completion pulse.
- `dm_req`  in  1  data request; held until `dm_valid` is seen.
- `dm_we`  in  1  write enable.
- `dm_be`  in  4  byte enables.
- `dm_addr`  in  ADDR_W  data address.
- `dm_wdata`  in  XLEN  store data.
- `dm_rdata`  out  XLEN  load data.
- `dm_valid`  out  1  one-cycle data completion pulse.
- `bus_err`  out  1  pulses together with the valid of an aborted transaction.
- `stall_if`  out  1  = `if_req & ~if_valid`.
- `stall_mem`  out  1  = `dm_req & ~dm_valid`.
- `mem_req`, `mem_we`, `mem_be[3:0]`, `mem_addr[ADDR_W]`, `mem_wdata[XLEN]`  out  memory command.
- `mem_ready`  in  1  memory completes the current command this cycle.
- `mem_rdata`  in  XLEN  read data, valid when `mem_ready` is high.

## Operation
FSM states are IDLE, DATA and FETCH.

**IDLE**
- A requester is eligible when its `req` is 1 and its `valid` output is 0 this cycle. This masks the cycle in which the requester is consuming a result.
- `dm` has fixed priority over `if`, because the MEM stage holds the older instruction.
- If `dm` is eligible: latch `dm_we`, `dm_be`, `dm_addr`, `dm_wdata` into the command registers and go to DATA.
- Else if `if` is eligible and `if_kill` is 0: latch `if_addr`, force `we=0` and `be=4'hF`, and go to FETCH.

**DATA / FETCH**
- `mem_req` = 1 and all command fields stay stable until `mem_ready`.
- On `mem_ready`:
  - register `mem_rdata` into `dm_rdata` or `if_rdata`;
  - pulse the matching `valid` in the next cycle;
  - return to IDLE.
- On a store, `dm_rdata` is don't-care but `dm_valid` still pulses.

**Kill handling**
- `if_kill` asserted in any cycle while in FETCH sets a `kill_pending` flag.
- At `mem_ready`, if `kill_pending` or `if_kill` is set: no `if_valid` pulse, `if_rdata` is unchanged, and the flag is cleared.
- `if_kill` has no effect on DATA.

**Stall outputs**
- `stall_if` and `stall_mem` are combinational from the inputs and the registered valids. There are no other combinational paths to outputs.

**Reset**
- Synchronous `rst` returns the FSM to IDLE and clears `kill_pending` and the timeout counter.
- All registered outputs reset to 0, including `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`, both `rdata`, both `valid` and `bus_err`.
- Reset mid-transaction abandons the transaction silently: `mem_req` is low the cycle after reset is sampled.

## Timing
- IDLE request seen at edge t → `mem_req`=1 from cycle t+1.
- `mem_ready` in cycle t+1+k (k ≥ 0 wait cycles) → `valid` and `rdata` in cycle t+2+k, and the FSM is back in IDLE.
- Minimum fetch/load latency is 2 cycles. Throughput is one transaction per 2 cycles when `mem_ready` is immediate.
- If both requests are present in IDLE at t: DATA is issued at t+1, and FETCH is issued at the cycle after `dm_valid`, i.e. t+3 with k=0.
- `valid` is exactly one cycle wide. A requester holding `req` in that cycle is not re-issued.
- `mem_ready` is ignored in IDLE.

## Configuration
The macro is `MEM_ARB_TIMEOUT_EN`.

With the macro defined:
- A counter of width `$clog2(TIMEOUT_CYCLES+1)` clears on entering DATA/FETCH and increments each cycle `mem_ready` is 0.
- When the counter reaches `TIMEOUT_CYCLES` without `mem_ready`:
  - `mem_req` drops and the FSM returns to IDLE;
  - next cycle, the matching `valid` pulses with `bus_err`=1 and `rdata`=0;
  - a killed fetch suppresses both `valid` and `bus_err`.

Without the macro:
- There is no counter; the block waits indefinitely for `mem_ready`.
- `bus_err` is tied to 0.

## Test plan
- **Reset:** hold `rst` 2 cycles with both `req` high → all outputs 0 and `mem_req`=0 during reset; after release, `mem_req`=1 one cycle later with the DATA command.
- **Single fetch:** `if_req`, `if_addr`=0x100, `mem_ready` immediate, `mem_rdata`=0x00500093 → `mem_addr`=0x100 with `we=0`, `be=F`; `if_valid`=1 with `if_rdata`=0x00500093 two cycles after the request; `stall_if` high for exactly 2 cycles.
- **Simultaneous requests:** `dm_req` store (0x200, 0xDEADBEEF, be=4'b0011) and `if_req` (0x104) at the same edge → store issued first with exact be/wdata; fetch issued the cycle after `dm_valid`; no `if_valid` before `dm_valid`.
- **Kill:** `if_kill` pulsed during FETCH with 3 wait cycles → no `if_valid` and `if_rdata` unchanged; a new fetch (0x300) completes normally afterwards.
- **Wait states:** `mem_ready` delayed 5 cycles → `mem_addr`, `mem_we`, `mem_be`, `mem_wdata` stable all 6 cycles; `dm_valid` on cycle 7.
- **Timeout (`MEM_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4):** `mem_ready` never asserted on a load → `mem_req` drops after 4 wait cycles; `dm_valid`=`bus_err`=1 and `dm_rdata`=0 the next cycle.
